lms_ctr_spi_slave: RTL

- Memory-mapped SPI slave (peripheral-side endpoint) with an 8-bit frame, MSB first, CPOL=0, CPHA=1 (mode 1).
- Lets the LimeSDR-Mini soft CPU answer an external SPI master on the same 8-bit, mode-1 framing the master-side controllers use.
- The external SPI pins are asynchronous to clk. They are oversampled through synchronizers.
- The CPU side is a 3-bit-address register port with interrupt and streaming flags.

---
 rtl/lms_ctr_spi_slave.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lms_ctr_spi_slave.sv
// lms_ctr_spi_slave: memory-mapped SPI slave with an 8-bit frame, MSB first, mode 1 (CPOL=0, CPHA=1).
// The SPI pins are oversampled in the clk domain. The CPU sees a 3-bit-address register port.
module lms_ctr_spi_slave #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [7:0]  UNDERRUN_VALUE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic [7:0]  shift_reg, rx_hold, tx_hold, rx_byte, load_byte;
    logic [2:0]  bit_cnt;
    logic        tx_full, rrdy, roe, undr, abrt;
    logic [4:0]  ctrl;
    logic [15:0] status, rd_data;

    logic frame_start, frame_end, bit_rise, bit_fall, byte_done, load_evt, consume;
    logic rd_req, wr_req, rd_req_q, wr_req_q, rd_acc, wr_acc;
    logic rd_rx, wr_tx, wr_status, wr_ctrl;
    logic [2:0] w1c;
    logic unused_bits;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;

    // Synchronize the SPI pins and keep one more copy for edge detection.
    // SS_n resets to "low" so a select already asserted at reset release
    // produces no falling edge and is not mistaken for a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Frame next-state: a select falling edge opens a frame and a select rising edge closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign frame_start = (state_q == IDLE) & ss_fall;
    assign frame_end   = (state_q == ACTIVE) & ss_rise;
    assign bit_rise    = (state_q == ACTIVE) & ~ss_rise & sclk_rise;
    assign bit_fall    = (state_q == ACTIVE) & ~ss_rise & sclk_fall;
    assign byte_done   = bit_fall & (bit_cnt == 3'd7);
    assign load_evt    = frame_start | byte_done;
    assign consume     = load_evt & tx_full;
    assign rx_byte     = {shift_reg[6:0], mosi_s};
    assign load_byte   = tx_full ? tx_hold : UNDERRUN_VALUE;

    assign rd_req    = spi_select & ~read_n;
    assign wr_req    = spi_select & ~write_n;
    assign rd_acc    = rd_req & ~rd_req_q;
    assign wr_acc    = wr_req & ~wr_req_q;
    assign rd_rx     = rd_acc & (mem_addr == 3'd0);
    // A write that lands on a reload cycle goes into the slot the reload just emptied.
    assign wr_tx     = wr_acc & (mem_addr == 3'd1) & (~tx_full | consume);
    assign wr_status = wr_acc & (mem_addr == 3'd2);
    assign wr_ctrl   = wr_acc & (mem_addr == 3'd3);
    assign w1c       = wr_status ? data_from_cpu[4:2] : 3'b000;

    assign status        = {10'd0, ~ss_s, abrt, undr, roe, ~tx_full, rrdy};
    assign MISO_oe       = (state_q == ACTIVE);
    assign dataavailable = rrdy;
    assign readyfordata  = ~tx_full;
    assign unused_bits   = ^data_from_cpu[15:8];

    // Read data select for the register port.
    always_comb begin
        rd_data = '0;
        case (mem_addr)
            3'd0:    rd_data = {8'd0, rx_hold};
            3'd2:    rd_data = status;
            3'd3:    rd_data = {11'd0, ctrl};
            default: rd_data = '0;
        endcase
    end

    // Serial datapath: drive MISO on rising SCLK, shift on falling SCLK, reload each byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            MISO      <= 1'b0;
            rx_hold   <= '0;
        end else begin
            if (frame_start) begin
                shift_reg <= load_byte;
                bit_cnt   <= '0;
            end else if (frame_end) begin
                bit_cnt   <= '0;
            end else begin
                if (bit_rise) MISO <= shift_reg[7];
                if (bit_fall) begin
                    bit_cnt   <= bit_cnt + 3'd1;
                    shift_reg <= byte_done ? load_byte : rx_byte;
                end
                if (byte_done) rx_hold <= rx_byte;
            end
        end
    end

    // CPU register port, TX holding slot, status flags and interrupt.
    // On every flag a new event takes priority over a W1C or a read-clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            data_to_cpu <= '0;
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            undr        <= 1'b0;
            abrt        <= 1'b0;
            ctrl        <= '0;
            irq         <= 1'b0;
        end else begin
            rd_req_q <= rd_req;
            wr_req_q <= wr_req;
            if (rd_acc)  data_to_cpu <= rd_data;
            if (wr_ctrl) ctrl <= data_from_cpu[4:0];
            if (wr_tx) begin
                tx_hold <= data_from_cpu[7:0];
                tx_full <= 1'b1;
            end else if (consume) begin
                tx_full <= 1'b0;
            end
            if (byte_done)  rrdy <= 1'b1;
            else if (rd_rx) rrdy <= 1'b0;
            roe  <= (byte_done & rrdy & ~rd_rx) | (roe & ~w1c[0]);
            undr <= (load_evt & ~tx_full) | (undr & ~w1c[1]);
            abrt <= (frame_end & (bit_cnt != 3'd0)) | (abrt & ~w1c[2]);
            irq  <= |(status[4:0] & ctrl);
        end
    end

endmodule
